// File: rtl/mc_bus_pkg.sv
// Shared types and constants for the MCU/SRAM bridge: controller state encoding
// and the per-byte power-up fill pattern of the shared memory.
package mc_bus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_WR   = 2'd2,
      ST_TURN = 2'd3
   } mc_state_e;

   // Even words power up as 0101..., odd words as the complement.
   localparam logic [7:0] PAT_BYTE_EVEN = 8'h5A;
   localparam logic [7:0] PAT_BYTE_ODD  = 8'hA5;

endpackage

// File: rtl/mc_sync.sv
// Multi-flop synchroniser for one asynchronous, active-low MCU strobe.
// Reset drives it to the inactive level (1).
module mc_sync #(
   parameter int STAGES = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[STAGES-2:0], d};
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync_q <= '1;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q = sync_q[STAGES-1];

endmodule

// File: rtl/mc_sram_bridge.sv
// Asynchronous MCU bus to dual-access SRAM bridge with a synchronous fabric port.
// Define MC_BYTE_LANE_EN to add the active-low mc_bl_n byte-lane write mask.
//
// state   | meaning
// IDLE    | waiting for a clean read or write strobe combination
// RD      | MCU read; pads driven from the second RD clock onwards
// WR      | MCU write; address/data tracked every clock until the strobe rises
// TURN    | one-clock bus turnaround, pads released
module mc_sram_bridge
   import mc_bus_pkg::*;
#(
   parameter int MC_DATA_WIDTH = 16,
   parameter int MC_ADD_WIDTH  = 6,
   parameter int SYNC_STAGES   = 2
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     mc_ce,
   input  logic                     mc_oe,
   input  logic                     mc_we,
   input  logic [MC_ADD_WIDTH-1:0]  mc_add,
   input  logic [MC_DATA_WIDTH-1:0] mc_din,
`ifdef MC_BYTE_LANE_EN
   input  logic [MC_DATA_WIDTH/8-1:0] mc_bl_n,
`endif
   output logic [MC_DATA_WIDTH-1:0] mc_dout,
   output logic                     mc_data_oe,
   input  logic [MC_ADD_WIDTH-1:0]  fab_addr,
   input  logic [MC_DATA_WIDTH-1:0] fab_wdata,
   input  logic                     fab_we,
   output logic [MC_DATA_WIDTH-1:0] fab_rdata,
   output logic                     fab_collide
);

   localparam int NB   = MC_DATA_WIDTH / 8;
   localparam int HALF = 1 << (MC_ADD_WIDTH - 1);

   typedef logic [MC_DATA_WIDTH-1:0] word_t;

   localparam word_t PAT_EVEN = {NB{PAT_BYTE_EVEN}};
   localparam word_t PAT_ODD  = {NB{PAT_BYTE_ODD}};

   logic ce_s, oe_s, we_s;

   mc_sync #(.STAGES(SYNC_STAGES)) u_sync_ce (.clock(clock), .reset(reset), .d(mc_ce), .q(ce_s));
   mc_sync #(.STAGES(SYNC_STAGES)) u_sync_oe (.clock(clock), .reset(reset), .d(mc_oe), .q(oe_s));
   mc_sync #(.STAGES(SYNC_STAGES)) u_sync_we (.clock(clock), .reset(reset), .d(mc_we), .q(we_s));

   logic [NB-1:0] bl_in;
`ifdef MC_BYTE_LANE_EN
   assign bl_in = mc_bl_n;
`else
   assign bl_in = '0;
`endif

   // Split into even/odd banks so each can carry its own power-up fill; reset leaves them alone.
   word_t mem_even_q [HALF] = '{default: PAT_EVEN};
   word_t mem_odd_q  [HALF] = '{default: PAT_ODD};

   function automatic word_t mem_rd(input logic [MC_ADD_WIDTH-1:0] a);
      return a[0] ? mem_odd_q[a[MC_ADD_WIDTH-1:1]] : mem_even_q[a[MC_ADD_WIDTH-1:1]];
   endfunction

   mc_state_e               state_q, state_d;
   logic [MC_ADD_WIDTH-1:0] addr_q, addr_d;
   word_t                   din_q, din_d;
   logic [NB-1:0]           bl_q, bl_d;
   word_t                   dout_q, dout_d;
   logic                    data_oe_q, data_oe_d;
   word_t                   fab_rdata_q, fab_rdata_d;
   logic                    collide_q, collide_d;
   logic                    rd_req, wr_req, commit, same_word;
   word_t                   base, merged;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      din_d   = din_q;
      bl_d    = bl_q;
      dout_d  = dout_q;
      commit  = 1'b0;
      rd_req  = !ce_s && !oe_s && we_s;
      wr_req  = !ce_s && !we_s && oe_s;

      case (state_q)
         ST_IDLE: begin
            if (rd_req) begin
               state_d = ST_RD;
               addr_d  = mc_add;
               dout_d  = mem_rd(mc_add);
            end else if (wr_req) begin
               state_d = ST_WR;
               addr_d  = mc_add;
               din_d   = mc_din;
               bl_d    = bl_in;
            end
         end
         ST_RD: begin
            if (ce_s || oe_s) begin
               state_d = ST_TURN;
            end else if (mc_add != addr_q) begin
               addr_d = mc_add;
               dout_d = mem_rd(mc_add);
            end
         end
         ST_WR: begin
            // The commit uses the word captured on the previous clock, not this one.
            if (ce_s || we_s) begin
               commit  = 1'b1;
               state_d = ST_TURN;
            end else begin
               addr_d = mc_add;
               din_d  = mc_din;
               bl_d   = bl_in;
            end
         end
         ST_TURN: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      data_oe_d = (state_q == ST_RD) && (state_d == ST_RD);

      same_word = commit && fab_we && (fab_addr == addr_q);
      collide_d = same_word;

      // On a same-word collision the fabric data is the base the MCU lanes overwrite.
      base   = same_word ? fab_wdata : mem_rd(addr_q);
      merged = base;
      for (int l = 0; l < NB; l++) begin
         merged[l*8 +: 8] = bl_q[l] ? base[l*8 +: 8] : din_q[l*8 +: 8];
      end

      fab_rdata_d = mem_rd(fab_addr);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         din_q       <= '0;
         bl_q        <= '0;
         dout_q      <= '0;
         data_oe_q   <= 1'b0;
         fab_rdata_q <= '0;
         collide_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         din_q       <= din_d;
         bl_q        <= bl_d;
         dout_q      <= dout_d;
         data_oe_q   <= data_oe_d;
         fab_rdata_q <= fab_rdata_d;
         collide_q   <= collide_d;
      end
   end

   always_ff @(posedge clock) begin
      if (commit) begin
         if (addr_q[0]) mem_odd_q[addr_q[MC_ADD_WIDTH-1:1]]  <= merged;
         else           mem_even_q[addr_q[MC_ADD_WIDTH-1:1]] <= merged;
      end
      if (fab_we && !same_word) begin
         if (fab_addr[0]) mem_odd_q[fab_addr[MC_ADD_WIDTH-1:1]]  <= fab_wdata;
         else             mem_even_q[fab_addr[MC_ADD_WIDTH-1:1]] <= fab_wdata;
      end
   end

   assign mc_dout     = dout_q;
   assign mc_data_oe  = data_oe_q;
   assign fab_rdata   = fab_rdata_q;
   assign fab_collide = collide_q;

endmodule

// File: tb/tb_mc_sram_bridge.sv
// Directed bench for mc_sram_bridge: word-level memory model, per-cycle output checks
// plus literal expectations for the documented scenarios.
module tb_mc_sram_bridge;

   localparam int DW = 16;
   localparam int AW = 6;
   localparam int SS = 2;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          mc_ce = 1'b1, mc_oe = 1'b1, mc_we = 1'b1;
   logic [AW-1:0] mc_add = '0;
   logic [DW-1:0] mc_din = '0;
`ifdef MC_BYTE_LANE_EN
   logic [1:0]    mc_bl_n = '0;
`endif
   logic [DW-1:0] mc_dout;
   logic          mc_data_oe;
   logic [AW-1:0] fab_addr = '0;
   logic [DW-1:0] fab_wdata = '0;
   logic          fab_we = 1'b0;
   logic [DW-1:0] fab_rdata;
   logic          fab_collide;

   int errors = 0;
   int checks = 0;

   logic [DW-1:0] mem_m [2**AW];

   logic          fab_chk = 1'b0, rd_active = 1'b0, rd_steady = 1'b0, coll_win = 1'b0;
   logic [AW-1:0] rd_addr = '0;
   logic          fab_chk_s = 1'b0, rd_active_s = 1'b0, rd_steady_s = 1'b0, coll_win_s = 1'b0;
   logic [AW-1:0] fab_addr_s = '0, rd_addr_s = '0;

   always #5 clock = ~clock;

   mc_sram_bridge #(
      .MC_DATA_WIDTH(DW),
      .MC_ADD_WIDTH (AW),
      .SYNC_STAGES  (SS)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .mc_ce      (mc_ce),
      .mc_oe      (mc_oe),
      .mc_we      (mc_we),
      .mc_add     (mc_add),
      .mc_din     (mc_din),
`ifdef MC_BYTE_LANE_EN
      .mc_bl_n    (mc_bl_n),
`endif
      .mc_dout    (mc_dout),
      .mc_data_oe (mc_data_oe),
      .fab_addr   (fab_addr),
      .fab_wdata  (fab_wdata),
      .fab_we     (fab_we),
      .fab_rdata  (fab_rdata),
      .fab_collide(fab_collide)
   );

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // Expectation flags are latched at the active edge and applied at the following falling edge.
   always @(posedge clock) begin
      fab_chk_s   <= fab_chk && !fab_we && !reset;
      fab_addr_s  <= fab_addr;
      rd_active_s <= rd_active;
      rd_steady_s <= rd_steady;
      rd_addr_s   <= rd_addr;
      coll_win_s  <= coll_win;
   end

   always @(negedge clock) begin
      if (!rd_active_s) check1("oe_outside_read", mc_data_oe, 1'b0);
      if (rd_steady_s) begin
         check1("rd_oe_steady", mc_data_oe, 1'b1);
         check("rd_dout_steady", mc_dout, mem_m[rd_addr_s]);
      end
      if (fab_chk_s) check("fab_rdata_model", fab_rdata, mem_m[fab_addr_s]);
      if (!coll_win_s) check1("collide_quiet", fab_collide, 1'b0);
   end

   task automatic mcu_read(input logic [AW-1:0] addr, input logic [AW-1:0] addr2,
                           input logic [DW-1:0] lit);
      @(negedge clock);
      mc_add = addr; mc_ce = 1'b0; mc_oe = 1'b0; rd_active = 1'b1;
      for (int k = 1; k <= SS + 2; k++) begin
         @(negedge clock);
         check1($sformatf("rd_latency_edge%0d", k), mc_data_oe, k == SS + 2);
      end
      check("rd_dout_literal", mc_dout, lit);
      check("rd_dout_model", mc_dout, mem_m[addr]);
      rd_addr = addr; rd_steady = 1'b1;
      repeat (3) @(negedge clock);
      if (addr2 != addr) begin
         rd_steady = 1'b0;
         mc_add = addr2;
         @(negedge clock);
         check("rd_readdress", mc_dout, mem_m[addr2]);
         check1("rd_readdress_oe", mc_data_oe, 1'b1);
         rd_addr = addr2; rd_steady = 1'b1;
         repeat (2) @(negedge clock);
      end
      rd_steady = 1'b0;
      mc_ce = 1'b1; mc_oe = 1'b1;
      for (int k = 1; k <= SS + 1; k++) begin
         @(negedge clock);
         check1($sformatf("rd_release_edge%0d", k), mc_data_oe, k <= SS);
      end
      @(negedge clock);
      rd_active = 1'b0;
   endtask

   task automatic mcu_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input logic [1:0] bl);
      fab_chk = 1'b0;
      @(negedge clock);
      mc_add = addr; mc_din = data; mc_ce = 1'b0; mc_we = 1'b0;
`ifdef MC_BYTE_LANE_EN
      mc_bl_n = bl;
`endif
      repeat (SS + 3) @(negedge clock);
      mc_we = 1'b1; mc_ce = 1'b1;
      repeat (SS + 1) @(negedge clock);
`ifdef MC_BYTE_LANE_EN
      for (int l = 0; l < 2; l++) if (!bl[l]) mem_m[addr][l*8 +: 8] = data[l*8 +: 8];
`else
      if (bl == 2'b00) mem_m[addr] = data;
`endif
      @(negedge clock);
      fab_chk = 1'b1;
   endtask

   task automatic mcu_write_fab(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                                input logic [AW-1:0] faddr, input logic [DW-1:0] fdata);
      fab_chk = 1'b0;
      @(negedge clock);
      mc_add = addr; mc_din = data; mc_ce = 1'b0; mc_we = 1'b0;
      repeat (SS + 3) @(negedge clock);
      mc_we = 1'b1; mc_ce = 1'b1;
      repeat (SS) @(negedge clock);
      fab_addr = faddr; fab_wdata = fdata; fab_we = 1'b1; coll_win = 1'b1;
      @(negedge clock);
      check1("collide_pulse", fab_collide, faddr == addr);
      fab_we = 1'b0;
      mem_m[faddr] = fdata;
      mem_m[addr]  = data;
      @(negedge clock);
      check1("collide_one_clock", fab_collide, 1'b0);
      coll_win = 1'b0;
      @(negedge clock);
      fab_chk = 1'b1;
   endtask

   task automatic fab_read(input logic [AW-1:0] addr, input logic [DW-1:0] lit);
      @(negedge clock);
      fab_addr = addr;
      @(negedge clock);
      check("fab_read_literal", fab_rdata, lit);
      check("fab_read_model", fab_rdata, mem_m[addr]);
   endtask

   task automatic fab_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
      fab_chk = 1'b0;
      @(negedge clock);
      fab_addr = addr; fab_wdata = data; fab_we = 1'b1;
      @(negedge clock);
      fab_we = 1'b0;
      mem_m[addr] = data;
      fab_chk = 1'b1;
   endtask

   initial begin
      for (int a = 0; a < 2**AW; a++) mem_m[a] = (a % 2 == 1) ? 16'hA5A5 : 16'h5A5A;

      repeat (3) @(negedge clock);
      check("reset_dout", mc_dout, 16'h0000);
      check1("reset_oe", mc_data_oe, 1'b0);
      check("reset_fab_rdata", fab_rdata, 16'h0000);
      check1("reset_collide", fab_collide, 1'b0);
      reset = 1'b0;
      fab_chk = 1'b1;

      mcu_read(6'h03, 6'h03, 16'hA5A5);

      mcu_write(6'h10, 16'h1234, 2'b00);
      mcu_read(6'h10, 6'h11, 16'h1234);
      fab_read(6'h10, 16'h1234);

      // All three strobes low is illegal: no access, no pad drive, memory untouched.
      @(negedge clock);
      mc_add = 6'h07; mc_din = 16'hDEAD;
      mc_ce = 1'b0; mc_oe = 1'b0; mc_we = 1'b0;
      repeat (SS + 8) @(negedge clock);
      mc_ce = 1'b1; mc_oe = 1'b1; mc_we = 1'b1;
      repeat (SS + 2) @(negedge clock);
      fab_read(6'h07, 16'hA5A5);
      mcu_read(6'h07, 6'h07, 16'hA5A5);

      mcu_write_fab(6'h20, 16'hBEEF, 6'h20, 16'h0F0F);
      fab_read(6'h20, 16'hBEEF);

      mcu_write_fab(6'h22, 16'h2222, 6'h21, 16'h1111);
      fab_read(6'h21, 16'h1111);
      fab_read(6'h22, 16'h2222);

      fab_write(6'h30, 16'hC3C3);
      mcu_read(6'h30, 6'h30, 16'hC3C3);

      // Reset in the middle of a write must drop it without a commit.
      fab_chk = 1'b0;
      @(negedge clock);
      mc_add = 6'h05; mc_din = 16'hFFFF; mc_ce = 1'b0; mc_we = 1'b0;
      repeat (SS + 3) @(negedge clock);
      #1;
      reset = 1'b1;
      mc_ce = 1'b1; mc_we = 1'b1;
      #1;
      check1("midwr_reset_oe", mc_data_oe, 1'b0);
      check("midwr_reset_dout", mc_dout, 16'h0000);
      check("midwr_reset_fab_rdata", fab_rdata, 16'h0000);
      check1("midwr_reset_collide", fab_collide, 1'b0);
      repeat (4) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      fab_chk = 1'b1;
      fab_read(6'h05, 16'hA5A5);
      mcu_read(6'h05, 6'h05, 16'hA5A5);

`ifdef MC_BYTE_LANE_EN
      mcu_write(6'h00, 16'hCDEF, 2'b10);
      fab_read(6'h00, 16'h5AEF);
`endif

      repeat (3) @(negedge clock);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mc_sram_bridge.md
MC_SRAM_BRIDGE -- requirements
Module: mc_sram_bridge

Interface
REQ-001 SHALL have parameter MC_DATA_WIDTH, default 16: MCU bus data width, multiple of 8.
REQ-002 SHALL have parameter MC_ADD_WIDTH, default 6: MCU address width; memory depth = 2**MC_ADD_WIDTH words.
REQ-003 SHALL have parameter SYNC_STAGES, default 2: synchroniser depth on mc_ce/mc_oe/mc_we, minimum 2.
REQ-004 SHALL have port clock, input, 1: single system clock, all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have ports mc_ce, mc_oe, mc_we, input, 1 each: active-low MCU strobes, asynchronous to clock.
REQ-007 SHALL have port mc_add, input, MC_ADD_WIDTH: MCU word address.
REQ-008 SHALL have port mc_din, input, MC_DATA_WIDTH: data from pad buffer.
REQ-009 SHALL have port mc_dout, output, MC_DATA_WIDTH: data to pad buffer.
REQ-010 SHALL have port mc_data_oe, output, 1: pad output enable, high = drive.
REQ-011 SHALL have ports fab_addr (MC_ADD_WIDTH), fab_wdata (MC_DATA_WIDTH), fab_we (1), input: fabric-side port.
REQ-012 SHALL have ports fab_rdata (MC_DATA_WIDTH) and fab_collide (1), output.

Function
REQ-013 SHALL pass mc_ce, mc_oe, mc_we through SYNC_STAGES flops; mc_add and mc_din SHALL be sampled only on the synchronised timing.
REQ-014 SHALL implement FSM states IDLE, RD, WR, TURN.
REQ-015 IDLE -> RD when sync ce=0, oe=0, we=1; IDLE -> WR when ce=0, we=0, oe=1; ce=0 with oe=0 and we=0 SHALL stay IDLE with no access.
REQ-016 On entry to RD, SHALL register mc_add and load mc_dout from memory; mc_data_oe SHALL rise on the following clock (read latency SYNC_STAGES+2 clocks from pin edge).
REQ-017 In RD, SHALL re-read when the sampled mc_add changes, updating mc_dout one clock later.
REQ-018 RD -> TURN when sync ce=1 or oe=1; mc_data_oe SHALL drop on the same clock edge that enters TURN.
REQ-019 In WR, SHALL capture mc_add and mc_din every clock; on sync we rising (or ce rising), SHALL commit the last captured word to memory and go to TURN.
REQ-020 TURN SHALL last exactly one clock, mc_data_oe low, then return to IDLE.
REQ-021 mc_data_oe SHALL be high only in RD after the first RD clock.
REQ-022 Fabric port: fab_rdata SHALL equal memory[fab_addr] one clock after fab_addr is presented; fab_we=1 SHALL write fab_wdata at that clock.
REQ-023 Fabric write and MCU commit to the same address in the same clock: MCU data SHALL win; fab_collide SHALL pulse high for one clock.
REQ-024 Simultaneous writes to different addresses SHALL both complete.
REQ-025 Memory SHALL power up with 0x5A5A-pattern (0101...) at even addresses and its complement at odd addresses, truncated/replicated to MC_DATA_WIDTH.

Reset
REQ-026 reset SHALL asynchronously force FSM to IDLE, mc_data_oe=0, mc_dout=0, fab_rdata=0, fab_collide=0, synchronisers to 1 (inactive).
REQ-027 reset asserted mid-WR SHALL abandon the write with no commit; memory contents SHALL NOT be cleared by reset.

Configuration
REQ-028 With MC_BYTE_LANE_EN defined, SHALL add input mc_bl_n, MC_DATA_WIDTH/8 bits, active-low, captured with mc_din; commit SHALL update only lanes with mc_bl_n=0.
REQ-029 Without MC_BYTE_LANE_EN, mc_bl_n SHALL be absent and every commit SHALL write the full word.

Structure
REQ-030 Package mc_bus_pkg SHALL hold the FSM state encoding and the power-up pattern constants.
REQ-031 Synchroniser SHALL be sub-module mc_sync (parameter STAGES, reset value 1), instantiated per strobe.
REQ-032 Pad tristate buffers SHALL remain in the top level, outside this block.

Verification
REQ-033 Read addr 0x03 after reset -> mc_data_oe rises SYNC_STAGES+2 clocks after ce/oe fall, mc_dout=0xA5A5.
REQ-034 Write 0x1234 to 0x10, then read 0x10 -> mc_dout=0x1234; fabric read of 0x10 -> fab_rdata=0x1234.
REQ-035 ce/oe/we all low for 8 clocks -> state stays IDLE, mc_data_oe=0, no memory change.
REQ-036 MCU commit 0xBEEF and fab_we 0x0F0F to 0x20 in the same clock -> memory[0x20]=0xBEEF, fab_collide one-clock pulse.
REQ-037 reset asserted mid-WR of 0xFFFF to 0x05 -> mc_data_oe=0, memory[0x05] keeps 0xA5A5.
REQ-038 With MC_BYTE_LANE_EN, write 0xCDEF to 0x00 with mc_bl_n=2'b10 -> memory[0x00]=0x5AEF.
